// File: rtl/sync_fifo_memory_if.sv
// Handshake and status bundle between a byte producer/consumer and sync_fifo_memory.
// The master side drives requests and write data; the slave side is the FIFO itself.
`timescale 1ns/1ps
interface sync_fifo_memory_if #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output wr_en, rd_en, data_in,
      input  data_out, full, empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, rd_en, data_in,
      output data_out, full, empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_memory.sv
// Single-clock FIFO with registered read data, registered full/empty flags and
// one-cycle overflow/underflow pulses for rejected requests.
`timescale 1ns/1ps
module sync_fifo_memory #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input logic              clk,
   input logic              rst,
   sync_fifo_memory_if.slave bus
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   count_d;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  full_q;
   logic                  empty_q;
   logic                  overflow_q;
   logic                  underflow_q;
   logic                  wr_accept;
   logic                  rd_accept;

   // A read frees a slot in the same edge, so a full FIFO can still take a write
   // alongside a read; an empty FIFO never forwards the incoming word to the reader.
   always_comb begin
      rd_accept = bus.rd_en && !empty_q;
      wr_accept = bus.wr_en && (!full_q || rd_accept);
      count_d   = count_q;
      if (wr_accept && !rd_accept) begin
         count_d = count_q + 1'b1;
      end else if (rd_accept && !wr_accept) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         data_out_q  <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr     <= rd_ptr + 1'b1;
            data_out_q <= mem[rd_ptr];
         end
         count_q     <= count_d;
         full_q      <= (count_d == FULL_COUNT);
         empty_q     <= (count_d == '0);
         overflow_q  <= bus.wr_en && !wr_accept;
         underflow_q <= bus.rd_en && !rd_accept;
      end
   end

   assign bus.data_out  = data_out_q;
   assign bus.full      = full_q;
   assign bus.empty     = empty_q;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo_memory.sv
// Directed bench for sync_fifo_memory: reset, single word, fill/overflow, wrap,
// simultaneous access and mid-operation reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_sync_fifo_memory;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   sync_fifo_memory_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

   sync_fifo_memory #(.DATA_WIDTH(8), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present inputs, let one rising edge consume them, sample 1ns later.
   task automatic cyc(input logic wr, input logic rd, input logic [7:0] din);
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.data_in = din;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   initial begin
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      bus.data_in = 8'h99;

      // reset held for two edges with both requests asserted
      rst = 1'b0;
      cyc(1'b1, 1'b1, 8'h99);
      cyc(1'b1, 1'b1, 8'h99);
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_full", 32'(bus.full), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_data", 32'(bus.data_out), 32'h00);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      check("rst_udf", 32'(bus.underflow), 32'd0);
      rst = 1'b1;

      // single byte
      cyc(1'b1, 1'b0, 8'hAA);
      check("single_empty", 32'(bus.empty), 32'd0);
      check("single_count", 32'(bus.count), 32'd1);
      cyc(1'b0, 1'b0, 8'h00);
      check("idle_data_hold", 32'(bus.data_out), 32'h00);
      cyc(1'b0, 1'b1, 8'h00);
      check("single_rd_data", 32'(bus.data_out), 32'hAA);
      check("single_rd_empty", 32'(bus.empty), 32'd1);
      check("single_rd_count", 32'(bus.count), 32'd0);
      cyc(1'b1, 1'b0, 8'hBF);
      cyc(1'b0, 1'b1, 8'h00);
      check("bf_data", 32'(bus.data_out), 32'hBF);
      check("bf_empty", 32'(bus.empty), 32'd1);

      // fill, overflow, drain, underflow
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, 8'(i));
         if (i == 14) check("almost_full", 32'(bus.full), 32'd0);
      end
      check("fill_full", 32'(bus.full), 32'd1);
      check("fill_count", 32'(bus.count), 32'd16);
      check("fill_ovf_quiet", 32'(bus.overflow), 32'd0);
      cyc(1'b1, 1'b0, 8'hEE);
      check("ovf_pulse", 32'(bus.overflow), 32'd1);
      check("ovf_count", 32'(bus.count), 32'd16);
      cyc(1'b0, 1'b0, 8'h00);
      check("ovf_clear", 32'(bus.overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check("drain_data", 32'(bus.data_out), 32'(i));
      end
      check("drain_empty", 32'(bus.empty), 32'd1);
      check("drain_count", 32'(bus.count), 32'd0);
      cyc(1'b0, 1'b1, 8'h00);
      check("udf_pulse", 32'(bus.underflow), 32'd1);
      check("udf_data_hold", 32'(bus.data_out), 32'h0F);
      cyc(1'b0, 1'b0, 8'h00);
      check("udf_clear", 32'(bus.underflow), 32'd0);

      // wrap-around (pointers start at 2 here, second batch crosses 15->0)
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
      check("wrap1_count", 32'(bus.count), 32'd10);
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check("wrap1_data", 32'(bus.data_out), 32'(8'h20 + i));
      end
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
      check("wrap2_count", 32'(bus.count), 32'd12);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check("wrap2_data", 32'(bus.data_out), 32'(8'h20 + i));
      end
      check("wrap2_count_end", 32'(bus.count), 32'd0);
      check("wrap2_empty", 32'(bus.empty), 32'd1);

      // simultaneous read and write while full
      for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
      cyc(1'b1, 1'b1, 8'h55);
      check("full_rw_data", 32'(bus.data_out), 32'h40);
      check("full_rw_full", 32'(bus.full), 32'd1);
      check("full_rw_count", 32'(bus.count), 32'd16);
      check("full_rw_ovf", 32'(bus.overflow), 32'd0);
      for (int i = 1; i < 16; i++) begin
         cyc(1'b0, 1'b1, 8'h00);
         check("full_rw_drain", 32'(bus.data_out), 32'(8'h40 + i));
      end
      cyc(1'b0, 1'b1, 8'h00);
      check("full_rw_last", 32'(bus.data_out), 32'h55);
      check("full_rw_empty", 32'(bus.empty), 32'd1);

      // simultaneous read and write while empty: write only
      cyc(1'b1, 1'b1, 8'h77);
      check("empty_rw_udf", 32'(bus.underflow), 32'd1);
      check("empty_rw_count", 32'(bus.count), 32'd1);
      check("empty_rw_hold", 32'(bus.data_out), 32'h55);
      cyc(1'b0, 1'b1, 8'h00);
      check("empty_rw_read", 32'(bus.data_out), 32'h77);
      check("empty_rw_empty", 32'(bus.empty), 32'd1);

      // reset in the middle of operation
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
      check("pre_rst_count", 32'(bus.count), 32'd5);
      rst = 1'b0;
      cyc(1'b1, 1'b1, 8'h99);
      rst = 1'b1;
      check("mid_rst_empty", 32'(bus.empty), 32'd1);
      check("mid_rst_count", 32'(bus.count), 32'd0);
      check("mid_rst_data", 32'(bus.data_out), 32'h00);
      check("mid_rst_full", 32'(bus.full), 32'd0);
      cyc(1'b1, 1'b0, 8'h3C);
      cyc(1'b0, 1'b1, 8'h00);
      check("post_rst_data", 32'(bus.data_out), 32'h3C);
      check("post_rst_empty", 32'(bus.empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sync_fifo_memory.md
Name: sync_fifo_memory

Overview:
- Single-clock synchronous FIFO buffer with a registered read port and full/empty status flags.
- Decouples a byte producer from a byte consumer in the same clock domain.
- Writes and reads use independent enables; overflow and underflow attempts are ignored and flagged.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- DEPTH, 16, number of storage entries; power of two, minimum 2.
- ADDR_WIDTH, log2(DEPTH) = 4, pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous active-low reset (0 = reset), sampled on the rising edge of clk.
- wr_en  input  1  write request; data_in is stored on this edge if accepted.
- rd_en  input  1  read request; the head word is popped to data_out if accepted.
- data_in  input  DATA_WIDTH  write data.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when the FIFO holds DEPTH words.
- empty  output  1  high when the FIFO holds 0 words.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write was rejected.
- underflow  output  1  one-cycle pulse when a read was rejected.

Behaviour:
- Reset (rst=0 at a clock edge): write pointer, read pointer and count are 0; data_out=0; empty=1; full=0; overflow=0; underflow=0. Memory contents need not be cleared. Reset overrides wr_en and rd_en in the same cycle.
- A reset asserted mid-operation discards all stored words. The first accepted write after reset lands at address 0.
- Write acceptance: wr_en=1 and (full=0 or a read is accepted in the same cycle).
  - Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH.
- Read acceptance: rd_en=1 and empty=0.
  - Accepted read: data_out <= mem[rd_ptr]; rd_ptr increments modulo DEPTH.
- Read latency: data_out shows the popped word after the same edge that accepts the read, i.e. one cycle after rd_en is presented.
- data_out holds its last value when no read is accepted.
- No fall-through: when empty, a simultaneous write and read accepts only the write. The read is rejected and underflow pulses.
- When full, a simultaneous read and write are both accepted. count stays at DEPTH and full stays 1.
- count update:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on both or neither.
- full and empty are registered and derived from the next count value: full = (count==DEPTH), empty = (count==0). Both are valid in the cycle after the causing edge.
- Pointers wrap from DEPTH-1 to 0 with no gap. Ordering is strictly first-in first-out across wrap-around.
- overflow pulses for one cycle after an edge where wr_en=1 but the write was rejected. underflow pulses likewise for a rejected read. Neither flag is sticky.
- Rejected operations change no state other than their flag.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=0 for 2 edges with wr_en=rd_en=1 -> empty=1, full=0, count=0, data_out=0x00, no flag pulses.
- Single byte: write 0xAA for one cycle -> empty=0, count=1. Idle one cycle, then rd_en for one cycle -> data_out=0xAA, empty=1, count=0. Then write 0xBF and read it -> data_out=0xBF, empty=1.
- Fill and overflow: write 0x00..0x0F (16 words) -> full=1, count=16. Write 0xEE -> overflow pulses once, count stays 16. Read 16 -> data_out 0x00..0x0F in order, empty=1. Extra read -> underflow pulse, data_out stays 0x0F.
- Wrap-around: write 10, read 10, then write 12, read 12 (values 0x20..0x2B) -> output order exact, count returns to 0.
- Simultaneous: when full, wr_en=rd_en=1 with 0x55 -> oldest word out, full stays 1, 0x55 emerges last. When empty, wr_en=rd_en=1 with 0x77 -> underflow pulse, count=1, next read returns 0x77.
- Mid-operation reset: write 5 words, assert rst=0 one edge -> empty=1, count=0, data_out=0x00. Write 0x3C then read -> data_out=0x3C.
